mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 30 +++
 rtl/mul_div_unit_abs32.sv | 15 +
 rtl/mul_div_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the op_i encodings, the FSM state encodings and the iteration count.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  localparam int unsigned MDU_ITER  = 32;
  localparam int unsigned MDU_CNT_W = 5;
  localparam logic [MDU_CNT_W-1:0] MDU_CNT_LAST = MDU_CNT_W'(MDU_ITER - 1);

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_mul(input logic [1:0] op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_abs32.sv
// Conditional two's-complement negate of a 32-bit value.
// Used both to take operand magnitudes and to re-apply result signs.
// Ports:
//   a_i   : value in
//   neg_i : 1 = output -a_i, 0 = pass a_i through
//   y_o   : result
module mdu_abs32 (
  input  logic [31:0] a_i,
  input  logic        neg_i,
  output logic [31:0] y_o
);

  assign y_o = neg_i ? (~a_i + 32'd1) : a_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per clock, 32 steps.
// Ports:
//   clk_i, rst_i        : clock, async active-high reset
//   start_i, op_i       : begin MULTU/MULT/DIVU/DIV on rs_data_i, rt_data_i
//   mthi_i, mtlo_i      : move rs_data_i into HI / LO (IDLE or DONE only)
//   busy_o, done_o      : operation running / one-cycle completion pulse
//   hi_o, lo_o          : HI (product high / remainder), LO (product low / quotient)
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting; accepts start or HI/LO moves
// BUSY    | iterating, one step per clock for MDU_ITER clocks
// DONE    | result in HI/LO for one cycle; start here chains directly
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mdu_state_e           state_q, state_d;
  mdu_op_e              op_q, op_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]          acc_q, acc_d;
  logic [31:0]          b_q, b_d;
  logic [31:0]          hi_q, hi_d;
  logic [31:0]          lo_q, lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 neg_lo_q, neg_lo_d;

  logic [31:0] rs_mag, rt_mag, hi_fix, lo_fix, hi_res;
  logic [63:0] acc_step;
  logic [32:0] add_sum;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic        rem_ge;
  logic        rs_neg, rt_neg;

  assign rs_neg = op_is_signed(op_i) & rs_data_i[31];
  assign rt_neg = op_is_signed(op_i) & rt_data_i[31];

  mdu_abs32 u_abs_rs (.a_i(rs_data_i),        .neg_i(rs_neg),   .y_o(rs_mag));
  mdu_abs32 u_abs_rt (.a_i(rt_data_i),        .neg_i(rt_neg),   .y_o(rt_mag));
  mdu_abs32 u_abs_hi (.a_i(acc_step[63:32]),  .neg_i(neg_hi_q), .y_o(hi_fix));
  mdu_abs32 u_abs_lo (.a_i(acc_step[31:0]),   .neg_i(neg_lo_q), .y_o(lo_fix));

  // 64-bit negate of a product: high word is ~hi + carry-out of the low
  // negate, which is -hi minus one whenever the low word is non-zero.
  assign hi_res = hi_fix - {31'd0, op_is_mul(op_q) & neg_hi_q & (acc_step[31:0] != 32'd0)};

  always_comb begin
    add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    rem_sh   = acc_q[63:31];
    rem_ge   = rem_sh >= {1'b0, b_q};
    // When rem_ge holds, the difference is below the divisor and fits 32 bits.
    rem_sub  = rem_sh[31:0] - b_q;
    if (op_is_mul(op_q)) begin
      acc_step = {add_sum, acc_q[31:1]};
    end else begin
      acc_step = {(rem_ge ? rem_sub : rem_sh[31:0]), acc_q[30:0], rem_ge};
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_BUSY;
          op_d    = mdu_op_e'(op_i);
          cnt_d   = '0;
          acc_d   = {32'd0, rs_mag};
          b_d     = rt_mag;
          if (op_is_mul(op_i)) begin
            neg_hi_d = rs_neg ^ rt_neg;
            neg_lo_d = rs_neg ^ rt_neg;
          end else begin
            // Remainder follows the dividend; divide-by-zero keeps an
            // all-ones quotient, so its sign is never applied.
            neg_hi_d = rs_neg;
            neg_lo_d = (rs_neg ^ rt_neg) & (rt_data_i != '0);
          end
        end else begin
          state_d = ST_IDLE;
          if (mthi_i) hi_d = rs_data_i;
          if (mtlo_i) lo_d = rs_data_i;
        end
      end
      ST_BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MDU_CNT_LAST) begin
          hi_d    = hi_res;
          lo_d    = lo_fix;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULTU;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
    end
  end

  assign busy_o = (state_q == ST_BUSY);
  assign done_o = (state_q == ST_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
